// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display stage: FSM states and
// active-low segment patterns (bit0=a ... bit6=g).
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_7seg_display_seg7_encoder.sv
// One BCD digit to active-low segments; non-decimal codes show blank.
module seg7_encoder
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_7seg_display.sv
// Sequential double-dabble binary-to-BCD converter driving active-low
// seven-segment digits; re-converts whenever bin_in changes.
module bin_to_7seg_display
  import display_pkg::*;
#(
  parameter int N        = 6,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          bin_in,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic                  busy,
  output logic                  valid
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (pow10(DIGITS) <= ((64'd1 << N) - 64'd1)) begin : g_digits_check
    $error("DIGITS too small to represent every N-bit value");
  end

  state_e               state_q, state_d;
  logic                 pending_q, pending_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [7*DIGITS-1:0]  hex_q, hex_d;
  logic [N-1:0]         snap_q, snap_d;
  logic [N-1:0]         sh_q, sh_d;
  logic [N-1:0]         last_q, last_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [BW-1:0]        adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7*DIGITS-1:0]  seg_w;
  logic [7*DIGITS-1:0]  hex_enc;
  logic                 lz;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int d = 0; d < DIGITS; d++)
      if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
    return r;
  endfunction

  for (genvar d = 0; d < DIGITS; d++) begin : g_enc
    seg7_encoder u_enc (
      .digit_i (bcd_q[4*d +: 4]),
      .seg_o   (seg_w[7*d +: 7])
    );
  end

  // Walk from the most significant digit down; units digit is never blanked.
  always_comb begin
    hex_enc = seg_w;
    lz      = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      lz = lz && (bcd_q[4*d +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (d > 0) && lz) hex_enc[7*d +: 7] = SEG_BLANK;
    end
  end

  assign adj = add3(bcd_q);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    hex_d     = hex_q;
    snap_d    = snap_q;
    sh_d      = sh_q;
    last_d    = last_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (pending_q || (bin_in != last_q)) begin
          snap_d    = bin_in;
          sh_d      = bin_in;
          bcd_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          pending_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) state_d = DONE;
      end
      DONE: begin
        hex_d   = hex_enc;
        last_d  = snap_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      hex_q     <= '1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      hex_q     <= hex_d;
    end
  end

  // Datapath needs no reset: the pending flag forces a fresh load first.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    sh_q   <= sh_d;
    last_q <= last_d;
    bcd_q  <= bcd_d;
    cnt_q  <= cnt_d;
  end

  assign hex_out = hex_q;
  assign busy    = busy_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_bin_to_7seg_display.sv
// Bench for bin_to_7seg_display: two instances (plain and leading-zero
// blanking) checked each cycle against a decimal reference model.
module tb_bin_to_7seg_display;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  bin = 6'd42;
  logic [13:0] hex0, hex1;
  logic        busy0, busy1, valid0, valid1;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tab [10];

  logic [13:0] m_hex0, m_hex1;
  logic        m_busy, m_valid, m_pend;
  int          m_left, m_snap, m_last;

  always #5 clk = ~clk;

  bin_to_7seg_display #(.N(6), .DIGITS(2), .BLANK_LZ(0)) dut0 (
    .clk (clk), .rst (rst), .bin_in (bin),
    .hex_out (hex0), .busy (busy0), .valid (valid0)
  );

  bin_to_7seg_display #(.N(6), .DIGITS(2), .BLANK_LZ(1)) dut1 (
    .clk (clk), .rst (rst), .bin_in (bin),
    .hex_out (hex1), .busy (busy1), .valid (valid1)
  );

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
  end

  // Expected display of value v in decimal, optionally blanking leading zeros.
  function automatic logic [13:0] exp_hex(input int v, input bit blank);
    logic [6:0] d1, d0;
    d0 = seg_tab[v % 10];
    d1 = (blank && v < 10) ? 7'h7F : seg_tab[(v / 10) % 10];
    return {d1, d0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a conversion takes N+2 edges from load to display update.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hex0 = '1; m_hex1 = '1;
      m_busy = 1'b0; m_valid = 1'b0; m_pend = 1'b1; m_left = 0;
    end else if (m_left == 0) begin
      if (m_pend || int'(bin) != m_last) begin
        m_snap = int'(bin); m_left = N + 1; m_busy = 1'b1; m_pend = 1'b0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_hex0  = exp_hex(m_snap, 1'b0);
        m_hex1  = exp_hex(m_snap, 1'b1);
        m_valid = 1'b1; m_busy = 1'b0; m_last = m_snap;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_hex0", 32'(hex0), 32'(m_hex0));
    chk("model_hex1", 32'(hex1), 32'(m_hex1));
    chk("model_busy0", 32'(busy0), 32'(m_busy));
    chk("model_busy1", 32'(busy1), 32'(m_busy));
    chk("model_valid0", 32'(valid0), 32'(m_valid));
    chk("model_valid1", 32'(valid1), 32'(m_valid));
  end

  task automatic show(input logic [5:0] v, input string nm,
                      input logic [13:0] e0, input logic [13:0] e1);
    bin = v;
    tick(8);
    chk({nm, "_hex0"}, 32'(hex0), 32'(e0));
    chk({nm, "_hex1"}, 32'(hex1), 32'(e1));
    chk({nm, "_valid"}, 32'(valid0), 32'd1);
    chk({nm, "_busy"}, 32'(busy0), 32'd0);
  endtask

  initial begin
    tick(2);
    chk("rst_hex0", 32'(hex0), 32'h3FFF);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    rst = 1'b0;
    tick(7);
    chk("lat_busy_e7", 32'(busy0), 32'd1);
    chk("lat_valid_e7", 32'(valid0), 32'd0);
    chk("lat_hex_e7", 32'(hex0), 32'h3FFF);
    tick(1);
    chk("lat42_hex0", 32'(hex0), 32'({7'b0011001, 7'b0100100}));
    chk("lat42_valid", 32'(valid0), 32'd1);
    chk("lat42_busy", 32'(busy0), 32'd0);

    show(6'd63, "v63", {7'b0000010, 7'b0110000}, {7'b0000010, 7'b0110000});
    show(6'd0,  "v0",  {7'b1000000, 7'b1000000}, {7'b1111111, 7'b1000000});
    show(6'd9,  "v9",  {7'b1000000, 7'b0010000}, {7'b1111111, 7'b0010000});
    show(6'd10, "v10", {7'b1111001, 7'b1000000}, {7'b1111001, 7'b1000000});
    show(6'd0,  "v0b", {7'b1000000, 7'b1000000}, {7'b1111111, 7'b1000000});

    // Change the input mid-conversion: 42 displays first, then 41.
    bin = 6'd42;
    tick(2);
    bin = 6'd41;
    tick(6);
    chk("chg_hex42", 32'(hex0), 32'({7'b0011001, 7'b0100100}));
    tick(1);
    chk("chg_busy_again", 32'(busy0), 32'd1);
    tick(7);
    chk("chg_hex41", 32'(hex0), 32'({7'b0011001, 7'b1111001}));

    // Reset asserted mid-conversion acts immediately.
    bin = 6'd5;
    tick(3);
    rst = 1'b1;
    #1;
    chk("arst_hex0", 32'(hex0), 32'h3FFF);
    chk("arst_valid", 32'(valid0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(8);
    chk("arst5_hex0", 32'(hex0), 32'({7'b1000000, 7'b0010010}));
    chk("arst5_hex1", 32'(hex1), 32'({7'b1111111, 7'b0010010}));

    for (int v = 0; v < 64; v++) begin
      bin = 6'(v);
      tick(8);
      chk("exh_hex0", 32'(hex0), 32'(exp_hex(v, 1'b0)));
      chk("exh_hex1", 32'(hex1), 32'(exp_hex(v, 1'b1)));
    end
    bin = 6'd0;
    tick(8);
    bin = 6'd63;
    tick(8);
    chk("wrap_hex0", 32'(hex0), 32'({7'b0000010, 7'b0110000}));

    for (int i = 0; i < 200; i++) begin
      bin = 6'($urandom_range(0, 63));
      tick($urandom_range(1, 12));
    end
    tick(12);
    chk("rand_final_busy", 32'(busy0), 32'd0);
    chk("rand_final_hex0", 32'(hex0), 32'(exp_hex(int'(bin), 1'b0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
